// File: rtl/rca_pipe_pkg.sv
// Shared definitions for the pipelined ripple-carry adder/subtractor.
// Latency: n/a (types, defaults and a combinational full-adder helper only).
// Backpressure: n/a.
package rca_pipe_pkg;

    localparam int NB_DATA_DEF  = 16;
    localparam int N_STAGES_DEF = 4;

    // One full-adder result bit pair
    typedef struct packed {
        logic co;
        logic s;
    } fa_t;

    // Single-bit full adder; the slice ripples through one of these per bit
    function automatic fa_t fa(input logic a, input logic b, input logic ci);
        fa_t r;
        r.s  = a ^ b ^ ci;
        r.co = (a & b) | (ci & (a ^ b));
        return r;
    endfunction

endpackage

// File: rtl/rca_pipe_slice.sv
// Combinational NB_SLICE-bit ripple-carry slice built from full-adder cells.
// Latency: 0 cycles (purely combinational; the parent registers its outputs).
// Backpressure: none.
module rca_pipe_slice
    import rca_pipe_pkg::*;
#(
    parameter int NB_SLICE = 4
) (
    input  logic [NB_SLICE-1:0] a_i,
    input  logic [NB_SLICE-1:0] b_i,
    input  logic                c_i,
    output logic [NB_SLICE-1:0] sum_o,
    output logic                c_o,
    output logic                c_msb_o
);

    // carry[j] is the carry into bit j; carry[NB_SLICE] leaves the slice
    logic [NB_SLICE:0] carry;

    // Ripple the carry from bit 0 upwards, one full adder per bit
    always_comb begin
        fa_t bit_r;
        bit_r    = '0;
        carry    = '0;
        sum_o    = '0;
        carry[0] = c_i;
        for (int j = 0; j < NB_SLICE; j++) begin
            bit_r        = fa(a_i[j], b_i[j], carry[j]);
            sum_o[j]     = bit_r.s;
            carry[j+1]   = bit_r.co;
        end
    end

    assign c_o     = carry[NB_SLICE];
    assign c_msb_o = carry[NB_SLICE-1];

endmodule

// File: rtl/rca_pipe.sv
// Pipelined NB_DATA-bit ripple-carry add/subtract, one NB_SLICE carry slice per stage.
// Latency: exactly N_STAGES cycles from i_valid sample to o_valid; 1 op/cycle.
// Backpressure: none; i_clear flushes in-flight valids (and drops a same-cycle i_valid).
module rca_pipe
    import rca_pipe_pkg::*;
#(
    parameter int NB_DATA  = NB_DATA_DEF,
    parameter int N_STAGES = N_STAGES_DEF
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_clear,
    input  logic               i_valid,
    input  logic               i_sub,
    input  logic [NB_DATA-1:0] i_a,
    input  logic [NB_DATA-1:0] i_b,
    input  logic               i_c,
    output logic               o_valid,
    output logic [NB_DATA-1:0] o_sum,
    output logic               o_c,
    output logic               o_ovf
);

    localparam int NB_SLICE = NB_DATA / N_STAGES;

    // Subtraction is a + ~b + ~borrow; invert once at the input so every slice just adds
    logic [NB_DATA-1:0] b_eff;
    logic               cin_eff;

    assign b_eff   = i_sub ? ~i_b : i_b;
    assign cin_eff = i_sub ? ~i_c : i_c;

    for (genvar k = 0; k < N_STAGES; k++) begin : g_stage
        // Result bits accumulated so far: slices 0..k, lower slices already de-skewed
        localparam int W_SUM = (k + 1) * NB_SLICE;

        logic [NB_SLICE-1:0] a_sl;
        logic [NB_SLICE-1:0] b_sl;
        logic [NB_SLICE-1:0] s_sl;
        logic                c_in;
        logic                c_out;
        logic                c_msb;
        logic [W_SUM-1:0]    sum_d;
        logic [W_SUM-1:0]    sum_q;
        logic                c_q;
        logic                vld_d;
        logic                vld_q;

        if (k == 0) begin : g_src
            assign a_sl  = i_a[NB_SLICE-1:0];
            assign b_sl  = b_eff[NB_SLICE-1:0];
            assign c_in  = cin_eff;
            assign sum_d = s_sl;
            assign vld_d = i_valid;
        end else begin : g_src
            // Operand slice k has been skewed by k registers to meet its carry here
            assign a_sl  = g_stage[k-1].g_op.opa_q[NB_SLICE-1:0];
            assign b_sl  = g_stage[k-1].g_op.opb_q[NB_SLICE-1:0];
            assign c_in  = g_stage[k-1].c_q;
            assign sum_d = {s_sl, g_stage[k-1].sum_q};
            assign vld_d = g_stage[k-1].vld_q;
        end

        rca_pipe_slice #(
            .NB_SLICE (NB_SLICE)
        ) u_slice (
            .a_i     (a_sl),
            .b_i     (b_sl),
            .c_i     (c_in),
            .sum_o   (s_sl),
            .c_o     (c_out),
            .c_msb_o (c_msb)
        );

        // Stage result/carry/valid; data loads every cycle, clear only kills valids
        always_ff @(posedge i_clk or negedge i_rst_n) begin
            if (!i_rst_n) begin
                sum_q <= '0;
                c_q   <= 1'b0;
                vld_q <= 1'b0;
            end else begin
                sum_q <= sum_d;
                c_q   <= c_out;
                vld_q <= vld_d & ~i_clear;
            end
        end

        if (k < N_STAGES - 1) begin : g_op
            // Operand bits not yet consumed, slice k+1 sitting in the low NB_SLICE bits
            localparam int W_OP = (N_STAGES - 1 - k) * NB_SLICE;

            logic [W_OP-1:0] opa_d;
            logic [W_OP-1:0] opb_d;
            logic [W_OP-1:0] opa_q;
            logic [W_OP-1:0] opb_q;

            if (k == 0) begin : g_opsrc
                assign opa_d = i_a[NB_DATA-1:NB_SLICE];
                assign opb_d = b_eff[NB_DATA-1:NB_SLICE];
            end else begin : g_opsrc
                assign opa_d = g_stage[k-1].g_op.opa_q[W_OP+NB_SLICE-1:NB_SLICE];
                assign opb_d = g_stage[k-1].g_op.opb_q[W_OP+NB_SLICE-1:NB_SLICE];
            end

            // Skew register for the still-pending upper operand slices
            always_ff @(posedge i_clk or negedge i_rst_n) begin
                if (!i_rst_n) begin
                    opa_q <= '0;
                    opb_q <= '0;
                end else begin
                    opa_q <= opa_d;
                    opb_q <= opb_d;
                end
            end
        end

        if (k == N_STAGES - 1) begin : g_out
            logic ovf_q;

            // Signed overflow: carry into the MSB disagrees with carry out of it
            always_ff @(posedge i_clk or negedge i_rst_n) begin
                if (!i_rst_n) begin
                    ovf_q <= 1'b0;
                end else begin
                    ovf_q <= c_msb ^ c_out;
                end
            end

            assign o_sum   = sum_q;
            assign o_c     = c_q;
            assign o_valid = vld_q;
            assign o_ovf   = ovf_q;
        end else begin : g_mid
            // Only the top slice's MSB carry feeds the overflow flag
            logic unused_msb;
            assign unused_msb = c_msb;
        end
    end

endmodule

// File: tb/tb_rca_pipe.sv
// Directed bench for rca_pipe at NB_DATA=16, N_STAGES=4.
// Latency: expects results exactly 4 cycles after each accepted operation.
// Backpressure: none exercised (the design has none); flush and async reset are.
module tb_rca_pipe;

    localparam int NB = 16;
    localparam int NS = 4;

    logic          clk   = 1'b0;
    logic          rst_n = 1'b1;
    logic          clear = 1'b0;
    logic          valid = 1'b0;
    logic          sub   = 1'b0;
    logic          cin   = 1'b0;
    logic [NB-1:0] a     = '0;
    logic [NB-1:0] b     = '0;

    logic          o_valid;
    logic [NB-1:0] o_sum;
    logic          o_c;
    logic          o_ovf;

    int n_cmp = 0;
    int n_bad = 0;

    logic [17:0]   exp_q [8];
    logic [NB-1:0] ra;
    logic [NB-1:0] rb;
    logic          rc;
    logic          rs;

    always #5 clk = ~clk;

    rca_pipe #(
        .NB_DATA  (NB),
        .N_STAGES (NS)
    ) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .i_clear (clear),
        .i_valid (valid),
        .i_sub   (sub),
        .i_a     (a),
        .i_b     (b),
        .i_c     (cin),
        .o_valid (o_valid),
        .o_sum   (o_sum),
        .o_c     (o_c),
        .o_ovf   (o_ovf)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference {ovf, carry, sum} from plain integer arithmetic
    function automatic logic [17:0] golden(input logic [15:0] ga, input logic [15:0] gb,
                                           input logic gc, input logic gs);
        int          ua, ub, sa, sb, ru, rsg;
        logic [31:0] ru_v;
        logic        cy, ov;
        ua = int'(ga);
        ub = int'(gb);
        sa = int'($signed(ga));
        sb = int'($signed(gb));
        if (!gs) begin
            ru  = ua + ub + int'(gc);
            rsg = sa + sb + int'(gc);
            cy  = (ru > 65535);
        end else begin
            ru  = ua - ub - int'(gc);
            rsg = sa - sb - int'(gc);
            cy  = (ru >= 0);
        end
        ov   = (rsg > 32767) || (rsg < -32768);
        ru_v = ru;
        return {ov, cy, ru_v[15:0]};
    endfunction

    task automatic drive(input logic [15:0] ta, input logic [15:0] tb_v, input logic tc,
                         input logic ts, input logic tv, input logic tclr);
        a     = ta;
        b     = tb_v;
        cin   = tc;
        sub   = ts;
        valid = tv;
        clear = tclr;
    endtask

    task automatic check_out(input string tag, input logic [17:0] e);
        check({tag, ".sum"}, 32'(o_sum), 32'(e[15:0]));
        check({tag, ".c"},   32'(o_c),   32'(e[16]));
        check({tag, ".ovf"}, 32'(o_ovf), 32'(e[17]));
    endtask

    // One isolated op: valid must stay low for 3 cycles, rise on the 4th, then drop
    task automatic run_single(input string tag, input logic [15:0] ta, input logic [15:0] tb_v,
                              input logic tc, input logic ts, input logic [17:0] e);
        drive(ta, tb_v, tc, ts, 1'b1, 1'b0);
        tick();
        drive('0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
        check({tag, ".v1"}, 32'(o_valid), 32'd0);
        tick();
        check({tag, ".v2"}, 32'(o_valid), 32'd0);
        tick();
        check({tag, ".v3"}, 32'(o_valid), 32'd0);
        tick();
        check({tag, ".v4"}, 32'(o_valid), 32'd1);
        check_out(tag, e);
        tick();
        check({tag, ".v5"}, 32'(o_valid), 32'd0);
    endtask

    initial begin
        // Reset state
        #2 rst_n = 1'b0;
        tick();
        tick();
        check("rst.valid", 32'(o_valid), 32'd0);
        check("rst.sum",   32'(o_sum),   32'd0);
        check("rst.c",     32'(o_c),     32'd0);
        check("rst.ovf",   32'(o_ovf),   32'd0);
        rst_n = 1'b1;
        tick();

        // Directed single operations, expected {ovf, c, sum} worked by hand
        run_single("add",      16'h1234, 16'h1111, 1'b0, 1'b0, {1'b0, 1'b0, 16'h2345});
        run_single("carry",    16'hFFFF, 16'h0000, 1'b1, 1'b0, {1'b0, 1'b1, 16'h0000});
        run_single("sub_ovf",  16'h8000, 16'h0001, 1'b0, 1'b1, {1'b1, 1'b1, 16'h7FFF});
        run_single("sub_neg",  16'h0003, 16'h0005, 1'b0, 1'b1, {1'b0, 1'b0, 16'hFFFE});
        run_single("add_ovf",  16'h7FFF, 16'h0001, 1'b0, 1'b0, {1'b1, 1'b0, 16'h8000});
        run_single("sub_bin",  16'h0010, 16'h0001, 1'b1, 1'b1, {1'b0, 1'b1, 16'h000E});
        run_single("sub_wrap", 16'h0000, 16'h0001, 1'b0, 1'b1, {1'b0, 1'b0, 16'hFFFF});

        // Back-to-back: 8 ops on consecutive cycles, results consecutive and in order
        for (int t = 0; t < 14; t++) begin
            if (t < 8) begin
                ra = 16'($urandom);
                rb = 16'($urandom);
                rc = 1'($urandom_range(0, 1));
                rs = 1'($urandom_range(0, 1));
                exp_q[t] = golden(ra, rb, rc, rs);
                drive(ra, rb, rc, rs, 1'b1, 1'b0);
            end else begin
                drive('0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
            end
            tick();
            check("b2b.valid", 32'(o_valid), 32'((t >= 3) && (t <= 10)));
            if ((t >= 3) && (t <= 10)) begin
                check_out("b2b", exp_q[t-3]);
            end
        end

        // Flush: ops at cycles 0..2 with clear at cycle 2 vanish; op at cycle 3 survives
        for (int t = 0; t < 10; t++) begin
            if (t < 2)       drive(16'h1000 + 16'(t), 16'h0001, 1'b0, 1'b0, 1'b1, 1'b0);
            else if (t == 2) drive(16'h2000, 16'h0002, 1'b0, 1'b0, 1'b1, 1'b1);
            else if (t == 3) drive(16'h00FF, 16'h0001, 1'b0, 1'b0, 1'b1, 1'b0);
            else             drive('0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
            tick();
            check("flush.valid", 32'(o_valid), 32'(t == 6));
            if (t == 6) begin
                check_out("flush", {1'b0, 1'b0, 16'h0100});
            end
        end

        // Async reset with operations in flight
        drive(16'hFFFF, 16'h0002, 1'b0, 1'b0, 1'b1, 1'b0);
        for (int t = 0; t < 4; t++) begin
            tick();
        end
        check("prerst.valid", 32'(o_valid), 32'd1);
        check_out("prerst", {1'b0, 1'b1, 16'h0001});
        #2 rst_n = 1'b0;
        drive('0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
        #1;
        check("midrst.valid", 32'(o_valid), 32'd0);
        check("midrst.sum",   32'(o_sum),   32'd0);
        check("midrst.c",     32'(o_c),     32'd0);
        check("midrst.ovf",   32'(o_ovf),   32'd0);
        tick();
        tick();
        rst_n = 1'b1;
        for (int t = 0; t < 6; t++) begin
            tick();
            check("postrst.nospur", 32'(o_valid), 32'd0);
        end
        run_single("postrst", 16'h00FF, 16'hFF01, 1'b0, 1'b0, {1'b0, 1'b1, 16'h0000});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
